// File: rtl/clock_pkg.sv
// clock_pkg: shared BCD limits, alarm state encoding and BCD increment helper.
package clock_pkg;

   localparam logic [7:0] BCD_MIN_MAX = 8'h59;
   localparam logic [7:0] BCD_HR_MAX  = 8'h23;

   typedef enum logic [1:0] {IDLE, RING, MUTED} state_t;

   // Wraps to 00 at limit; otherwise low nibble 9 carries into the high nibble.
   function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [7:0] limit);
      return (value == limit) ? 8'h00 :
             (value[3:0] == 4'h9) ? {value[7:4] + 4'h1, 4'h0} : value + 8'h01;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: raw key to stable level after DEB_CYCLES of agreement, plus a one-cycle press pulse.
module key_debounce #(
   parameter int DEB_CYCLES = 20000
) (
   input  logic CP,
   input  logic nCR,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          done;

   // done fires on the DEB_CYCLES-th consecutive cycle of disagreement
   assign done = (raw != level_q) && (cnt_q == CW'(DEB_CYCLES - 1));

   always_comb begin
      cnt_d   = (raw == level_q || done) ? '0 : cnt_q + CW'(1);
      level_d = done ? raw : level_q;
      press_d = done & raw;
   end

   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/alarm_bell.sv
// alarm_bell: BCD alarm time set by two debounced keys; rings a gated two-tone ALARM on match.
module alarm_bell
   import clock_pkg::*;
#(
   parameter int         DEB_CYCLES = 20000,
   parameter int         RING_SECS  = 60,
   parameter logic [7:0] RST_HR     = 8'h00,
   parameter logic [7:0] RST_MIN    = 8'h00
) (
   input  logic       CP,
   input  logic       nCR,
   input  logic       hz1_en,
   input  logic       tone_a,
   input  logic       tone_b,
   input  logic [7:0] Hour,
   input  logic [7:0] Minute,
   input  logic [7:0] Second,
   input  logic       SetHrKey,
   input  logic       SetMinKey,
   input  logic       CtrlBell,
   output logic [7:0] Set_Hr,
   output logic [7:0] Set_Min,
   output logic       ALARM,
   output logic       ringing
);

   localparam int RCW = $clog2(RING_SECS + 1);

   logic           hr_level, hr_press, min_level, min_press;
   state_t         state_q, state_d;
   logic [7:0]     set_hr_q, set_hr_d, set_min_q, set_min_d;
   logic [RCW-1:0] ring_cnt_q, ring_cnt_d;
   logic           phase_q, phase_d;
   logic           alarm_q, alarm_d;
   logic           ringing_q, ringing_d;
   logic           adjust, inc_hr, inc_min, time_eq, match;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_hr_key (
      .CP(CP), .nCR(nCR), .raw(SetHrKey), .level(hr_level), .press(hr_press)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_min_key (
      .CP(CP), .nCR(nCR), .raw(SetMinKey), .level(min_level), .press(min_press)
   );

   // A press coinciding with hz1_en still yields a single increment
   assign adjust  = state_q != RING;
   assign inc_hr  = adjust & (hr_press  | (hr_level  & hz1_en));
   assign inc_min = adjust & (min_press | (min_level & hz1_en));
   assign time_eq = (Hour == set_hr_q) && (Minute == set_min_q);
   assign match   = hz1_en & CtrlBell & time_eq & (Second == 8'h00);

   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
      phase_d    = phase_q;
      set_hr_d   = inc_hr  ? bcd_inc(set_hr_q,  BCD_HR_MAX)  : set_hr_q;
      set_min_d  = inc_min ? bcd_inc(set_min_q, BCD_MIN_MAX) : set_min_q;
      unique case (state_q)
         IDLE: if (match) begin
            state_d    = RING;
            ring_cnt_d = '0;
            phase_d    = 1'b0;
         end
         RING: if (!CtrlBell) state_d = IDLE;
         else if (hr_press || min_press) state_d = MUTED;
         else if (hz1_en) begin
            state_d    = (ring_cnt_q == RCW'(RING_SECS - 1)) ? IDLE : RING;
            ring_cnt_d = ring_cnt_q + RCW'(1);
            phase_d    = ~phase_q;
         end
         MUTED: if (!CtrlBell || !time_eq) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ringing_d = state_d == RING;
      alarm_d   = ringing_d & (phase_d ? tone_b : tone_a);
   end

   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         state_q    <= IDLE;
         set_hr_q   <= RST_HR;
         set_min_q  <= RST_MIN;
         ring_cnt_q <= '0;
         phase_q    <= 1'b0;
         alarm_q    <= 1'b0;
         ringing_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         set_hr_q   <= set_hr_d;
         set_min_q  <= set_min_d;
         ring_cnt_q <= ring_cnt_d;
         phase_q    <= phase_d;
         alarm_q    <= alarm_d;
         ringing_q  <= ringing_d;
      end
   end

   assign Set_Hr  = set_hr_q;
   assign Set_Min = set_min_q;
   assign ALARM   = alarm_q;
   assign ringing = ringing_q;

endmodule

// File: tb/tb_alarm_bell.sv
// tb_alarm_bell: vector table plus hand sequences, checked through an expected-value queue.
module tb_alarm_bell;

   localparam int DEB = 8;

   logic       CP = 1'b0, nCR = 1'b0, hz1_en = 1'b0, tone_a = 1'b0, tone_b = 1'b0;
   logic [7:0] Hour = 8'h12, Minute = 8'h45, Second = 8'h01;
   logic       SetHrKey = 1'b0, SetMinKey = 1'b0, CtrlBell = 1'b0;
   logic [7:0] Set_Hr, Set_Min;
   logic       ALARM, ringing;

   alarm_bell #(.DEB_CYCLES(DEB), .RING_SECS(60), .RST_HR(8'h00), .RST_MIN(8'h00)) dut (
      .CP(CP), .nCR(nCR), .hz1_en(hz1_en), .tone_a(tone_a), .tone_b(tone_b),
      .Hour(Hour), .Minute(Minute), .Second(Second),
      .SetHrKey(SetHrKey), .SetMinKey(SetMinKey), .CtrlBell(CtrlBell),
      .Set_Hr(Set_Hr), .Set_Min(Set_Min), .ALARM(ALARM), .ringing(ringing)
   );

   always #5 CP = ~CP;

   typedef struct {
      string      name;
      logic [7:0] v;
   } exp_t;

   typedef struct {
      logic       hz, ta, tb;
      logic [7:0] sec;
      logic       ring, alarm;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[7];
   int   errors = 0;
   int   checks = 0;
   int   early;

   task automatic sb_push(input string n, input logic [7:0] v);
      sb.push_back('{n, v});
   endtask

   task automatic sb_check(input logic [7:0] act);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %h required nothing", act);
      end else begin
         e = sb.pop_front();
         if (act !== e.v) begin
            errors++;
            $display("FAIL %s: got %h required %h", e.name, act, e.v);
         end
      end
   endtask

   task automatic step();
      @(posedge CP);
      #1;
   endtask

   task automatic pulse();
      hz1_en = 1'b1;
      step();
      hz1_en = 1'b0;
   endtask

   // press, then n-1 auto-repeat pulses, then release and let it settle
   task automatic hold(input bit hr, input int n);
      if (hr) SetHrKey = 1'b1; else SetMinKey = 1'b1;
      repeat (DEB + 2) step();
      for (int i = 1; i < n; i++) begin
         pulse();
         step();
      end
      SetHrKey  = 1'b0;
      SetMinKey = 1'b0;
      repeat (DEB + 2) step();
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1};

      #2;
      sb_push("rst_set_hr", 8'h00);   sb_check(Set_Hr);
      sb_push("rst_set_min", 8'h00);  sb_check(Set_Min);
      sb_push("rst_alarm", 8'h00);    sb_check({7'd0, ALARM});
      sb_push("rst_ringing", 8'h00);  sb_check({7'd0, ringing});
      step();
      nCR = 1'b1;
      step();

      hold(1'b0, 59);
      hold(1'b1, 22);
      sb_push("setup_min59", 8'h59);  sb_check(Set_Min);

      repeat (5) begin
         SetMinKey = 1'b1;
         repeat (3) step();
         SetMinKey = 1'b0;
         repeat (2) step();
      end
      SetMinKey = 1'b1;
      repeat (DEB + 2) step();
      sb_push("bounce_min_wrap", 8'h00); sb_check(Set_Min);
      sb_push("bounce_hr_kept", 8'h22);  sb_check(Set_Hr);
      SetMinKey = 1'b0;
      repeat (DEB + 2) step();
      sb_push("bounce_single_inc", 8'h00); sb_check(Set_Min);

      SetHrKey = 1'b1;
      repeat (DEB + 2) step();
      sb_push("hr_press_23", 8'h23); sb_check(Set_Hr);
      pulse(); step();
      sb_push("hr_repeat_00", 8'h00); sb_check(Set_Hr);
      pulse(); step();
      sb_push("hr_repeat_01", 8'h01); sb_check(Set_Hr);
      pulse(); step();
      sb_push("hr_repeat_02", 8'h02); sb_check(Set_Hr);
      SetHrKey = 1'b0;
      repeat (DEB + 2) step();

      hold(1'b1, 5);
      hold(1'b0, 30);
      sb_push("alarm_hr_07", 8'h07);  sb_check(Set_Hr);
      sb_push("alarm_min_30", 8'h30); sb_check(Set_Min);

      Hour = 8'h07; Minute = 8'h30; CtrlBell = 1'b1;
      for (int i = 0; i < 7; i++) begin
         hz1_en = tbl[i].hz; tone_a = tbl[i].ta; tone_b = tbl[i].tb; Second = tbl[i].sec;
         sb_push($sformatf("tbl%0d_ringing", i), {7'd0, tbl[i].ring});
         sb_push($sformatf("tbl%0d_alarm", i), {7'd0, tbl[i].alarm});
         step();
         sb_check({7'd0, ringing});
         sb_check({7'd0, ALARM});
      end
      hz1_en = 1'b0; tone_a = 1'b1; tone_b = 1'b1;
      early = 0;
      repeat (57) begin
         pulse(); step();
         if (!ringing) early++;
      end
      sb_push("ring_held_59", 8'd0); sb_check(early[7:0]);
      pulse();
      sb_push("ring_end_ringing", 8'h00); sb_check({7'd0, ringing});
      sb_push("ring_end_alarm", 8'h00);   sb_check({7'd0, ALARM});

      Second = 8'h00; pulse(); Second = 8'h01;
      sb_push("mute_ring_start", 8'h01); sb_check({7'd0, ringing});
      sb_push("mute_alarm_on", 8'h01);   sb_check({7'd0, ALARM});
      hold(1'b0, 1);
      sb_push("muted_ringing", 8'h00); sb_check({7'd0, ringing});
      sb_push("muted_alarm", 8'h00);   sb_check({7'd0, ALARM});
      sb_push("muted_min_30", 8'h30);  sb_check(Set_Min);
      Second = 8'h00; pulse(); Second = 8'h01;
      sb_push("muted_no_rering", 8'h00); sb_check({7'd0, ringing});
      Minute = 8'h31; step(); Minute = 8'h30;
      pulse();
      sb_push("no_ring_0730_01", 8'h00); sb_check({7'd0, ringing});
      Second = 8'h00; pulse(); Second = 8'h01;
      sb_push("rearmed_ring", 8'h01); sb_check({7'd0, ringing});

      CtrlBell = 1'b0; step();
      sb_push("bell_off_ringing", 8'h00); sb_check({7'd0, ringing});
      sb_push("bell_off_alarm", 8'h00);   sb_check({7'd0, ALARM});
      Second = 8'h00; pulse(); step();
      sb_push("bell_off_match", 8'h00); sb_check({7'd0, ringing});

      CtrlBell = 1'b1; pulse();
      sb_push("pre_reset_ring", 8'h01); sb_check({7'd0, ringing});
      #2 nCR = 1'b0;
      #1;
      sb_push("async_rst_ringing", 8'h00); sb_check({7'd0, ringing});
      sb_push("async_rst_alarm", 8'h00);   sb_check({7'd0, ALARM});
      sb_push("async_rst_hr", 8'h00);      sb_check(Set_Hr);
      sb_push("async_rst_min", 8'h00);     sb_check(Set_Min);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
